// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration register writer.
// Frame layout: 2b address then 16b data, MSB first.
package cfg_pkg;

  localparam int unsigned FRAME_BITS = 18;
  localparam int unsigned ADR_W      = 2;
  localparam int unsigned DAT_W      = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned WRCNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    DRAIN  = 3'd5
  } state_e;

  // Address sits above data, matching the order bits arrive on the wire
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } reg_wr_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cfg_reg_writer.sv
// Deserializes 18-bit frames and writes them to the 4x16b config bank with
// address/data setup and hold around a registered write strobe.
module cfg_reg_writer
  import cfg_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = 1,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC     = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               ser_en_i,
  input  logic               ser_dat_i,
  output logic               reg_wr_o,
  output logic [ADR_W-1:0]   reg_adr_o,
  output logic [DAT_W-1:0]   reg_dat_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               frame_err_o,
  output logic               ovr_err_o,
  output logic [WRCNT_W-1:0] wr_cnt_o
);

  localparam int unsigned PH_MAX = max3(SETUP_CYC, WR_PULSE_CYC, HOLD_CYC);
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  state_e                 r_state, w_state_nxt;
  logic [PH_W-1:0]        r_phase, w_phase_nxt;
  logic [FRAME_BITS-1:0]  r_sr, w_sr_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_ovr_seen, w_ovr_seen_nxt;
  reg_wr_t                r_wr_data, w_wr_data_nxt;
  logic                   r_wr, w_wr_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_ferr, w_ferr_nxt;
  logic                   r_ovr, w_ovr_nxt;
  logic [WRCNT_W-1:0]     r_wrcnt, w_wrcnt_nxt;

  logic    w_shifting;
  logic    w_last_bit;
  logic    w_extra;
  logic    w_timed_nxt;
  reg_wr_t w_frame;

  assign w_shifting = (r_state == IDLE) || (r_state == SHIFT);
  assign w_last_bit = w_shifting && ser_en_i && (r_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_extra    = ser_en_i && !w_shifting;
  assign w_frame    = reg_wr_t'({r_sr[FRAME_BITS-2:0], ser_dat_i});

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; timed states leave when their phase count expires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (ser_en_i) w_state_nxt = SHIFT;
      SHIFT: begin
        if (!ser_en_i)      w_state_nxt = IDLE;
        else if (w_last_bit) w_state_nxt = SETUP;
      end
      SETUP:  if (r_phase == PH_W'(SETUP_CYC - 1))    w_state_nxt = STROBE;
      STROBE: if (r_phase == PH_W'(WR_PULSE_CYC - 1)) w_state_nxt = HOLD;
      HOLD:   if (r_phase == PH_W'(HOLD_CYC - 1))     w_state_nxt = ser_en_i ? DRAIN : IDLE;
      DRAIN:  if (!ser_en_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered-output next values, all derived from the next state
  always_comb begin
    w_sr_nxt       = r_sr;
    w_cnt_nxt      = r_cnt;
    w_ovr_seen_nxt = r_ovr_seen;
    w_wr_data_nxt  = r_wr_data;
    w_ferr_nxt     = 1'b0;
    w_ovr_nxt      = 1'b0;

    w_timed_nxt = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) || (w_state_nxt == HOLD);
    w_phase_nxt = (w_timed_nxt && (w_state_nxt == r_state)) ? r_phase + PH_W'(1) : '0;

    if (w_shifting && ser_en_i) begin
      if (w_last_bit) begin
        w_wr_data_nxt = w_frame;
        w_sr_nxt      = '0;
        w_cnt_nxt     = '0;
      end else begin
        w_sr_nxt  = {r_sr[FRAME_BITS-2:0], ser_dat_i};
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if ((r_state == SHIFT) && !ser_en_i) begin
      w_ferr_nxt = 1'b1;
      w_sr_nxt   = '0;
      w_cnt_nxt  = '0;
    end

    // Only the first surplus bit of a frame is flagged
    if (w_extra && !r_ovr_seen) begin
      w_ovr_nxt      = 1'b1;
      w_ovr_seen_nxt = 1'b1;
    end
    if (w_state_nxt == IDLE) w_ovr_seen_nxt = 1'b0;

    w_wr_nxt    = (w_state_nxt == STROBE);
    w_busy_nxt  = w_timed_nxt;
    w_done_nxt  = (w_state_nxt == HOLD) && (w_phase_nxt == PH_W'(HOLD_CYC - 1));
    w_wrcnt_nxt = ((w_state_nxt == STROBE) && (r_state != STROBE)) ?
                  r_wrcnt + WRCNT_W'(1) : r_wrcnt;
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_phase    <= '0;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovr_seen <= 1'b0;
      r_wr_data  <= '0;
      r_wr       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
      r_wrcnt    <= '0;
    end else begin
      r_phase    <= w_phase_nxt;
      r_sr       <= w_sr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovr_seen <= w_ovr_seen_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_wr       <= w_wr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_ferr     <= w_ferr_nxt;
      r_ovr      <= w_ovr_nxt;
      r_wrcnt    <= w_wrcnt_nxt;
    end
  end

  assign reg_wr_o    = r_wr;
  assign reg_adr_o   = r_wr_data.adr;
  assign reg_dat_o   = r_wr_data.dat;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign frame_err_o = r_ferr;
  assign ovr_err_o   = r_ovr;
  assign wr_cnt_o    = r_wrcnt;

endmodule

// File: tb/tb_cfg_reg_writer.sv
// Bench for cfg_reg_writer: default and (3,1,2) timing instances share one
// serial stream and are compared every cycle against a frame-level model.
module tb_cfg_reg_writer;
  import cfg_pkg::*;

  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_en = 1'b0;
  logic ser_dat = 1'b0;

  logic        wr    [NI];
  logic [1:0]  adr   [NI];
  logic [15:0] dat   [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        ferr  [NI];
  logic        ovr   [NI];
  logic [7:0]  wrcnt [NI];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cfg_reg_writer u_a (
    .clk_i(clk), .rst_n_i(rst_n), .ser_en_i(ser_en), .ser_dat_i(ser_dat),
    .reg_wr_o(wr[0]), .reg_adr_o(adr[0]), .reg_dat_o(dat[0]), .busy_o(busy[0]),
    .done_o(done[0]), .frame_err_o(ferr[0]), .ovr_err_o(ovr[0]), .wr_cnt_o(wrcnt[0])
  );

  cfg_reg_writer #(.SETUP_CYC(3), .WR_PULSE_CYC(1), .HOLD_CYC(2)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .ser_en_i(ser_en), .ser_dat_i(ser_dat),
    .reg_wr_o(wr[1]), .reg_adr_o(adr[1]), .reg_dat_o(dat[1]), .busy_o(busy[1]),
    .done_o(done[1]), .frame_err_o(ferr[1]), .ovr_err_o(ovr[1]), .wr_cnt_o(wrcnt[1])
  );

  function automatic int p_s(input int i); return (i == 0) ? 1 : 3; endfunction
  function automatic int p_w(input int i); return (i == 0) ? 2 : 1; endfunction
  function automatic int p_h(input int i); return (i == 0) ? 1 : 2; endfunction

  // Model: m_pos counts cycles since frame completion (1..S+W+H), 0 when not writing
  int          m_pos   [NI];
  int          m_nb    [NI];
  logic [17:0] m_sr    [NI];
  bit          m_drain [NI];
  bit          m_seen  [NI];
  bit          m_ferr  [NI];
  bit          m_ovr   [NI];
  logic [1:0]  m_adr   [NI];
  logic [15:0] m_dat   [NI];
  logic [7:0]  m_wrc   [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_pos[i] = 0; m_nb[i] = 0; m_sr[i] = '0; m_drain[i] = 0; m_seen[i] = 0;
      m_ferr[i] = 0; m_ovr[i] = 0; m_adr[i] = '0; m_dat[i] = '0; m_wrc[i] = '0;
    end
  endtask

  task automatic model_adv(input int i, input logic en, input logic d);
    int total;
    total = p_s(i) + p_w(i) + p_h(i);
    m_ferr[i] = 0;
    m_ovr[i]  = 0;
    if (m_pos[i] > 0 || m_drain[i]) begin
      if (en && !m_seen[i]) begin m_ovr[i] = 1; m_seen[i] = 1; end
      if (m_pos[i] == total) begin
        m_pos[i] = 0;
        m_drain[i] = en;
        if (!en) m_seen[i] = 0;
      end else if (m_pos[i] > 0) begin
        m_pos[i]++;
        if (m_pos[i] == p_s(i) + 1) m_wrc[i] = m_wrc[i] + 8'd1;
      end else if (!en) begin
        m_drain[i] = 0;
        m_seen[i] = 0;
      end
    end else if (en) begin
      m_sr[i] = {m_sr[i][16:0], d};
      m_nb[i]++;
      if (m_nb[i] == 18) begin
        m_adr[i] = m_sr[i][17:16];
        m_dat[i] = m_sr[i][15:0];
        m_nb[i] = 0;
        m_pos[i] = 1;
      end
    end else if (m_nb[i] > 0) begin
      m_ferr[i] = 1;
      m_nb[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
  endtask

  task automatic check_all();
    int total;
    for (int i = 0; i < NI; i++) begin
      total = p_s(i) + p_w(i) + p_h(i);
      chk("reg_wr",    i, 32'(wr[i]),    32'(m_pos[i] > p_s(i) && m_pos[i] <= p_s(i) + p_w(i)));
      chk("reg_adr",   i, 32'(adr[i]),   32'(m_adr[i]));
      chk("reg_dat",   i, 32'(dat[i]),   32'(m_dat[i]));
      chk("busy",      i, 32'(busy[i]),  32'(m_pos[i] > 0));
      chk("done",      i, 32'(done[i]),  32'(m_pos[i] == total));
      chk("frame_err", i, 32'(ferr[i]),  32'(m_ferr[i]));
      chk("ovr_err",   i, 32'(ovr[i]),   32'(m_ovr[i]));
      chk("wr_cnt",    i, 32'(wrcnt[i]), 32'(m_wrc[i]));
    end
  endtask

  // One cycle: check outputs settled from the last edge, then drive this cycle's inputs
  task automatic step(input logic en, input logic d);
    @(negedge clk);
    check_all();
    ser_en = en;
    ser_dat = d;
    for (int i = 0; i < NI; i++) model_adv(i, en, d);
  endtask

  task automatic send_bits(input logic [17:0] w, input int nbits);
    for (int j = 17; j > 17 - nbits; j--) step(1'b1, w[j]);
  endtask

  function automatic bit all_idle();
    return m_pos[0] == 0 && m_pos[1] == 0 && !m_drain[0] && !m_drain[1];
  endfunction

  task automatic wait_idle();
    for (int k = 0; k < 40 && !all_idle(); k++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    logic [17:0] w;
    int          mode;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single frame adr=2, dat=A5C3
    w = {2'd2, 16'hA5C3};
    send_bits(w, 18);
    wait_idle();
    repeat (3) step(1'b0, 1'b0);

    // Four frames, one per address
    for (int a = 0; a < 4; a++) begin
      w = {2'(a), 16'($urandom)};
      send_bits(w, 18);
      wait_idle();
    end

    // Truncated frame, then a clean one
    send_bits({2'd1, 16'h1234}, 9);
    repeat (3) step(1'b0, 1'b0);
    send_bits({2'd3, 16'hBEEF}, 18);
    wait_idle();

    // Enable held 25 cycles: one write plus surplus bits
    w = {2'd1, 16'h0F0F};
    send_bits(w, 18);
    for (int k = 0; k < 7; k++) step(1'b1, 1'($urandom));
    wait_idle();

    // Asynchronous reset in the middle of a strobe
    send_bits({2'd3, 16'hC001}, 18);
    for (int k = 0; k < 10 && !(m_pos[0] == p_s(0) + 1); k++) step(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("wr_before_rst", 0, 32'(wr[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr",    0, 32'(wr[0]),    32'd0);
    chk("rst_adr",   0, 32'(adr[0]),   32'd0);
    chk("rst_dat",   0, 32'(dat[0]),   32'd0);
    chk("rst_wrcnt", 0, 32'(wrcnt[0]), 32'd0);
    chk("rst_busy",  1, 32'(busy[1]),  32'd0);
    model_reset();
    repeat (2) step(1'b0, 1'b0);
    rst_n = 1'b1;
    send_bits({2'd2, 16'h5A5A}, 18);
    wait_idle();

    // Random mix of full, truncated and over-long frames with random gaps
    for (int n = 0; n < 60; n++) begin
      w = 18'($urandom);
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        send_bits(w, int'($urandom_range(1, 17)));
        step(1'b0, 1'b0);
      end else begin
        send_bits(w, 18);
        if (mode == 1) for (int k = 0; k < int'($urandom_range(1, 9)); k++) step(1'b1, 1'($urandom));
        if (mode == 2) for (int k = 0; k < 8; k++) step(1'($urandom), 1'($urandom));
      end
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) step(1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    // Enough frames to wrap the write counter
    for (int n = 0; n < 260; n++) begin
      send_bits(18'($urandom), 18);
      wait_idle();
    end

    repeat (3) step(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
